// File: rtl/point_read_arbiter.sv
// Port-B read arbiter for the point-memory RAM: round-robin between two requesters,
// per-requester outstanding limit, bounds check, fixed-latency in-order responses.
module point_read_arbiter #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 26,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_OUT      = 4
) (
    input  logic              clk_camera,
    input  logic              sys_rst,
    input  logic [ADDR_W-1:0] num_points,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);
    localparam int unsigned DEPTH = 1 + READ_LATENCY;

    logic [2:0]        r_cnt0;
    logic [2:0]        r_cnt1;
    logic              r_last;
    logic [DEPTH-1:0]  r_tag_v;
    logic [DEPTH-1:0]  r_tag_id;
    logic [DEPTH-1:0]  r_tag_err;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_acc;
    logic [ADDR_W-1:0] w_acc_addr;
    logic              w_acc_err;
    logic              w_ret0;
    logic              w_ret1;

    always_comb begin
        w_elig0    = req0_valid && (r_cnt0 < 3'(MAX_OUT));
        w_elig1    = req1_valid && (r_cnt1 < 3'(MAX_OUT));
        // On contention the requester that did not win last time gets the slot.
        w_gnt0     = w_elig0 && (!w_elig1 || r_last);
        w_gnt1     = w_elig1 && !w_gnt0;
        w_acc      = w_gnt0 || w_gnt1;
        w_acc_addr = w_gnt1 ? req1_addr : req0_addr;
        w_acc_err  = w_acc && (w_acc_addr >= num_points);
        w_ret0     = r_tag_v[DEPTH-1] && !r_tag_id[DEPTH-1];
        w_ret1     = r_tag_v[DEPTH-1] && r_tag_id[DEPTH-1];
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp0_valid = w_ret0;
    assign rsp1_valid = w_ret1;
    assign rsp_err    = r_tag_v[DEPTH-1] && r_tag_err[DEPTH-1];
    // The last tag stage lines up with the RAM output word, so data is only gated here.
    assign rsp_data   = (r_tag_v[DEPTH-1] && !r_tag_err[DEPTH-1]) ? ram_doutb : '0;

    always_ff @(posedge clk_camera) begin
        if (sys_rst) begin
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_last    <= 1'b1;
            r_tag_v   <= '0;
            r_tag_id  <= '0;
            r_tag_err <= '0;
            ram_addrb <= '0;
        end else begin
            r_cnt0    <= r_cnt0 + {2'b00, w_gnt0} - {2'b00, w_ret0};
            r_cnt1    <= r_cnt1 + {2'b00, w_gnt1} - {2'b00, w_ret1};
            r_tag_v   <= {r_tag_v[DEPTH-2:0], w_acc};
            r_tag_id  <= {r_tag_id[DEPTH-2:0], w_gnt1};
            r_tag_err <= {r_tag_err[DEPTH-2:0], w_acc_err};
            if (w_acc) begin
                r_last    <= w_gnt1;
                ram_addrb <= w_acc_addr;
            end
        end
    end
endmodule
